audio_tone_seq: RTL and testbench

AUDIO_TONE_SEQ -- requirements
Module: audio_tone_seq

---
 rtl/audio_tone_seq.sv | 196 +++++++++++++++++++
 tb/tb_audio_tone_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_seq.sv
`default_nettype none
// ============================================================================
//  Module   : audio_tone_seq
//  Purpose  : Note sequencer that plays square-wave tones and rests for a set
//             number of duration ticks. It holds one active note and one
//             pending note, so back-to-back notes play with no gap.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk       : the only clock; all state changes on the rising edge
//    i_rst_n     : asynchronous active-low reset
//    i_enable    : output gate, 0 forces o_pulse low (timing unaffected)
//    i_valid     : note request valid
//    i_half_per  : tone half-period in clocks, 0 = rest
//    i_dur       : note duration in ticks
//    o_ready     : a note can be accepted this cycle (pending slot empty)
//    o_pulse     : square-wave tone output
//    o_busy      : a note (tone or rest) is active
//    o_done      : one-cycle pulse after each note completes
// ============================================================================
module audio_tone_seq #(
  parameter int CLK_FREQ = 12000000,
  parameter int TICK_HZ  = 1000,
  parameter int DIV_W    = 16,
  parameter int DUR_W    = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic [DIV_W-1:0] i_half_per,
  input  logic [DUR_W-1:0] i_dur,
  output logic             o_ready,
  output logic             o_pulse,
  output logic             o_busy,
  output logic             o_done
);

  localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
  localparam int PRESC_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] C_PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Active note
  logic [DIV_W-1:0]   act_half;
  logic [DUR_W-1:0]   act_dur;     // remaining ticks
  logic [DIV_W-1:0]   tone_cnt;
  logic               tone_lvl;
  logic [PRESC_W-1:0] presc;

  // Pending slot
  logic               pend_full;
  logic [DIV_W-1:0]   pend_half;
  logic [DUR_W-1:0]   pend_dur;

  logic               done_q;

  // Control decoded each cycle
  logic accept;
  logic tick_wrap;
  logic tone_hit;
  logic note_end;
  logic load_in;
  logic load_pend;
  logic store_pend;

  assign accept    = i_valid & ~pend_full;
  assign tick_wrap = (presc == C_PRESC_LAST);
  assign tone_hit  = (act_half != '0) && (tone_cnt == act_half - DIV_W'(1));
  // A zero-duration note ends on its first PLAY clock; otherwise the note
  // ends on the prescaler wrap that takes the remaining count from 1 to 0.
  assign note_end  = (state == ST_PLAY) &&
                     ((act_dur == '0) || (tick_wrap && (act_dur == DUR_W'(1))));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and load steering
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    load_in    = 1'b0;
    load_pend  = 1'b0;
    store_pend = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load_in   = 1'b1;
          state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (note_end) begin
          if (pend_full) begin
            load_pend = 1'b1;
          end else if (accept) begin
            // Bypass: the new note goes straight to the active registers.
            load_in = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (accept) begin
          store_pend = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Active note datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_half <= '0;
      act_dur  <= '0;
      tone_cnt <= '0;
      tone_lvl <= 1'b0;
      presc    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= note_end;
      if (load_in || load_pend) begin
        act_half <= load_pend ? pend_half : i_half_per;
        act_dur  <= load_pend ? pend_dur  : i_dur;
        tone_cnt <= '0;
        tone_lvl <= 1'b0;
        presc    <= '0;
      end else if (note_end) begin
        // Going idle: park everything so o_pulse stays low.
        tone_cnt <= '0;
        tone_lvl <= 1'b0;
        presc    <= '0;
      end else if (state == ST_PLAY) begin
        if (tick_wrap) begin
          presc   <= '0;
          act_dur <= act_dur - DUR_W'(1);
        end else begin
          presc <= presc + PRESC_W'(1);
        end
        if (act_half != '0) begin
          if (tone_hit) begin
            tone_lvl <= ~tone_lvl;
            tone_cnt <= '0;
          end else begin
            tone_cnt <= tone_cnt + DIV_W'(1);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending slot
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_full <= 1'b0;
      pend_half <= '0;
      pend_dur  <= '0;
    end else if (load_pend) begin
      pend_full <= 1'b0;
    end else if (store_pend) begin
      pend_full <= 1'b1;
      pend_half <= i_half_per;
      pend_dur  <= i_dur;
    end
  end

  assign o_ready = ~pend_full;
  assign o_busy  = (state == ST_PLAY);
  // tone_lvl is cleared whenever the sequencer is idle, so the gate alone
  // keeps o_pulse low outside a note.
  assign o_pulse = i_enable & tone_lvl;
  assign o_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_tone_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_tone_seq
//  Purpose  : Self-checking bench for audio_tone_seq. A note-level model
//             (elapsed time since note start, queue of one pending note)
//             predicts every output each cycle; directed scenarios add
//             literal timing expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_tone_seq;

  localparam int TICK_DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] half = '0;
  logic [11:0] dur = '0;
  logic        ready, pulse, busy, done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  audio_tone_seq #(
    .CLK_FREQ(1000),
    .TICK_HZ (100),
    .DIV_W   (16),
    .DUR_W   (12)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_enable  (en),
    .i_valid   (valid),
    .i_half_per(half),
    .i_dur     (dur),
    .o_ready   (ready),
    .o_pulse   (pulse),
    .o_busy    (busy),
    .o_done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // --------------------------------------------------------------------------
  // Note-level model
  // --------------------------------------------------------------------------
  bit m_act, m_pv, m_done, m_acc, m_end;
  int m_h, m_d, m_t, m_ph, m_pd;

  function automatic int note_len(input int d);
    return (d == 0) ? 1 : d * TICK_DIV;
  endfunction

  function automatic bit m_level();
    if (!m_act || m_h == 0) return 1'b0;
    return ((m_t / m_h) % 2) == 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_pv = 0; m_done = 0;
      m_h = 0; m_d = 0; m_t = 0; m_ph = 0; m_pd = 0;
    end else begin
      m_acc  = valid && !m_pv;
      m_end  = m_act && (m_t + 1 == note_len(m_d));
      m_done = m_end;
      if (m_end) begin
        if (m_pv) begin
          m_h = m_ph; m_d = m_pd; m_t = 0; m_pv = 0;
        end else if (m_acc) begin
          m_h = int'(half); m_d = int'(dur); m_t = 0;
        end else begin
          m_act = 0;
        end
      end else if (m_act) begin
        m_t = m_t + 1;
        if (m_acc) begin
          m_pv = 1; m_ph = int'(half); m_pd = int'(dur);
        end
      end else if (m_acc) begin
        m_act = 1; m_h = int'(half); m_d = int'(dur); m_t = 0;
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s at %0t: got %b, want %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy",  busy,  m_act);
    chk("ready", ready, !m_pv);
    chk("done",  done,  m_done);
    chk("pulse", pulse, en && m_level());
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  // Holds a request until accepted; returns at posedge+1 of the accept edge.
  task automatic offer(input int h, input int d, output int at);
    int  n;
    bit  r;
    half  = 16'(h);
    dur   = 12'(d);
    valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      r = ready;
      @(posedge clk);
      n = n + 1;
      if (r) break;
      if (n > 200) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL offer_timeout at %0t: not accepted in %0d cycles", $time, n);
        break;
      end
    end
    #1 valid = 1'b0;
    at = cyc;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  int a, b, c, r0, dcnt;

  initial begin
    // Reset state
    negs(1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_done",  done,  1'b0);
    chk("rst_pulse", pulse, 1'b0);
    sync();
    rst_n = 1'b1;

    // Single note H=3 D=2
    sync();
    offer(3, 2, a);
    negs(1);  chk("s1_busy_t0", busy, 1'b1); chk("s1_pulse_t0", pulse, 1'b0);
    negs(3);  chk("s1_pulse_t3", pulse, 1'b1);
    negs(3);  chk("s1_pulse_t6", pulse, 1'b0);
    negs(13); chk("s1_busy_t19", busy, 1'b1); chk("s1_done_t19", done, 1'b0);
    negs(1);  chk("s1_busy_t20", busy, 1'b0); chk("s1_done_t20", done, 1'b1);
    negs(1);  chk("s1_done_t21", done, 1'b0);

    // Back-to-back A(2,1) then B(5,1)
    sync();
    offer(2, 1, a);
    offer(5, 1, b);
    chk_int("s2_b_accept_edge", b - a, 1);
    negs(1);  chk("s2_ready_pend", ready, 1'b0);
    negs(8);  chk("s2_done_t9", done, 1'b0);
    negs(1);  chk("s2_done_t10", done, 1'b1); chk("s2_ready_t10", ready, 1'b1);
              chk("s2_busy_t10", busy, 1'b1); chk("s2_pulse_b0", pulse, 1'b0);
    negs(5);  chk("s2_pulse_b5", pulse, 1'b1);
    negs(5);  chk("s2_done_t20", done, 1'b1); chk("s2_busy_t20", busy, 1'b0);

    // Rest H=0 D=3
    sync();
    offer(0, 3, a);
    negs(1);  chk("s3_busy_t0", busy, 1'b1);
    negs(29); chk("s3_busy_t29", busy, 1'b1); chk("s3_pulse_t29", pulse, 1'b0);
              chk("s3_done_t29", done, 1'b0);
    negs(1);  chk("s3_done_t30", done, 1'b1); chk("s3_busy_t30", busy, 1'b0);

    // Enable gating mid-note H=4 D=5
    sync();
    offer(4, 5, a);
    negs(5);  chk("s4_pulse_t4", pulse, 1'b1);
    sync();   en = 1'b0;
    negs(1);  chk("s4_pulse_off_t5", pulse, 1'b0);
    negs(4);
    sync();   en = 1'b1;
    negs(1);  chk("s4_pulse_t10", pulse, 1'b0);
    negs(2);  chk("s4_pulse_t12", pulse, 1'b1);
    negs(37); chk("s4_busy_t49", busy, 1'b1); chk("s4_done_t49", done, 1'b0);
    negs(1);  chk("s4_done_t50", done, 1'b1); chk("s4_busy_t50", busy, 1'b0);

    // Zero duration, then third request held off while full
    sync();
    offer(1, 0, a);
    negs(1);  chk("s5_busy_t0", busy, 1'b1); chk("s5_pulse_t0", pulse, 1'b0);
    negs(1);  chk("s5_done_t1", done, 1'b1); chk("s5_busy_t1", busy, 1'b0);
              chk("s5_pulse_t1", pulse, 1'b0);
    sync();
    offer(3, 2, a);
    offer(2, 1, b);
    offer(4, 1, c);
    chk_int("s5_third_accept", c - a, 21);
    negs(1);  chk("s5_ready_full", ready, 1'b0);
    negs(25);

    // Reset mid-note with a pending note
    sync();
    offer(3, 5, a);
    offer(2, 2, b);
    negs(4);  chk("s6_pulse_t4", pulse, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("s6_rst_pulse", pulse, 1'b0);
    chk("s6_rst_busy",  busy,  1'b0);
    chk("s6_rst_ready", ready, 1'b1);
    sync();
    rst_n = 1'b1;
    r0 = cyc;
    offer(1, 1, c);
    chk_int("s6_accept_after_release", c - r0, 1);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      negs(1);
      if (done) dcnt = dcnt + 1;
    end
    chk_int("s6_no_stale_done", dcnt, 0);
    negs(1);  chk("s6_done_new", done, 1'b1);

    negs(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
